// File: rtl/keypad_defs.sv
// keypad_defs: constants, FSM state encoding and the entry-validation helper
// shared by the cooking-time keypad entry path.
package keypad_defs;

  localparam int NUM_KEYS     = 10;
  localparam int BCD_W        = 4;
  localparam int MAX_DIGITS   = 4;
  localparam int ENTRY_W      = 16;
  localparam int SEC_TENS_MAX = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    RELEASE  = 2'd2
  } state_t;

  // An entry can be loaded into the timer only if it is non-zero and its
  // seconds-tens digit is a real seconds value (0..5).
  function automatic logic entry_valid(input logic [ENTRY_W-1:0] e);
    return (e != '0) && (e[7:4] <= BCD_W'(SEC_TENS_MAX));
  endfunction

endpackage

// File: rtl/keypad_entry_ctrl_encoder.sv
// encoder: combinational 10-key to BCD encoder.
//   en         - enable; when low data_valid is forced low
//   keys       - synchronized key lines, bit n = digit n
//   bcd        - BCD code of the selected key (meaningful only with data_valid)
//   data_valid - at least one key is pressed and the encoder is enabled
// When several keys are pressed the lowest-numbered key wins.
module encoder
  import keypad_defs::*;
(
  input  logic                en,
  input  logic [NUM_KEYS-1:0] keys,
  output logic [BCD_W-1:0]    bcd,
  output logic                data_valid
);

  // lower_any[n] is set when any key below n is pressed.
  logic [NUM_KEYS:0]   lower_any;
  logic [NUM_KEYS-1:0] sel;

  assign lower_any[0] = 1'b0;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_prio
    assign lower_any[gi+1] = lower_any[gi] | keys[gi];
    assign sel[gi]         = keys[gi] & ~lower_any[gi];
  end

  always_comb begin
    bcd = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (sel[i]) bcd = bcd | BCD_W'(i);
    end
  end

  assign data_valid = en & lower_any[NUM_KEYS];

endmodule

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: synchronizes the raw keypad, encodes and debounces each
// key press, shifts accepted digits into a 4-digit mm:ss BCD entry register
// and hands a validated entry to the countdown timer on start.
//   clk, rst_n   - system clock, asynchronous active-low reset
//   keypad       - raw key lines (asynchronous), bit n = digit n
//   start        - load request (level; acted on at its rising edge)
//   clear        - erase entry (level)
//   timer_busy   - timer counting; keypad and start are ignored
//   entry        - {min_tens, min_ones, sec_tens, sec_ones}
//   digit_count  - digits entered, 0..4
//   key_strobe   - one-cycle pulse per accepted digit
//   load         - one-cycle load pulse to the timer
//   load_value   - value handed over with load, held until the next load
//   entry_error  - one-cycle pulse on a rejected start
module keypad_entry_ctrl
  import keypad_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] keypad,
  input  logic                start,
  input  logic                clear,
  input  logic                timer_busy,
  output logic [ENTRY_W-1:0]  entry,
  output logic [2:0]          digit_count,
  output logic                key_strobe,
  output logic                load,
  output logic [ENTRY_W-1:0]  load_value,
  output logic                entry_error
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  // Synchronizer
  logic [NUM_KEYS-1:0] sync1_reg, sync2_reg;

  // Encoder
  logic [BCD_W-1:0] bcd;
  logic             data_valid;

  // Debounce FSM
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [BCD_W-1:0] cand_reg, cand_next;
  logic             accept;
  logic [BCD_W-1:0] accept_digit;

  // Entry path
  logic [ENTRY_W-1:0] entry_reg, entry_next;
  logic [2:0]         count_reg, count_next;
  logic [ENTRY_W-1:0] load_value_reg, load_value_next;
  logic               strobe_reg, strobe_next;
  logic               load_reg, load_next;
  logic               error_reg, error_next;
  logic               start_d_reg;
  logic               start_evt;

  encoder u_encoder (
    .en         (!timer_busy),
    .keys       (sync2_reg),
    .bcd        (bcd),
    .data_valid (data_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg      <= '0;
      sync2_reg      <= '0;
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      cand_reg       <= '0;
      entry_reg      <= '0;
      count_reg      <= '0;
      load_value_reg <= '0;
      strobe_reg     <= 1'b0;
      load_reg       <= 1'b0;
      error_reg      <= 1'b0;
      start_d_reg    <= 1'b0;
    end else begin
      sync1_reg      <= keypad;
      sync2_reg      <= sync1_reg;
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      cand_reg       <= cand_next;
      entry_reg      <= entry_next;
      count_reg      <= count_next;
      load_value_reg <= load_value_next;
      strobe_reg     <= strobe_next;
      load_reg       <= load_next;
      error_reg      <= error_next;
      start_d_reg    <= start;
    end
  end

  // Debounce FSM: cnt counts matching observations in DEBOUNCE and idle
  // observations in RELEASE.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    cand_next    = cand_reg;
    accept       = 1'b0;
    accept_digit = cand_reg;
    case (state_reg)
      IDLE: begin
        if (data_valid) begin
          cand_next = bcd;
          if (CNT_MAX == CNT_ONE) begin
            // A single observation is already enough to accept.
            accept       = 1'b1;
            accept_digit = bcd;
            cnt_next     = '0;
            state_next   = RELEASE;
          end else begin
            cnt_next   = CNT_ONE;
            state_next = DEBOUNCE;
          end
        end
      end
      DEBOUNCE: begin
        if (data_valid && (bcd == cand_reg)) begin
          if (cnt_reg + CNT_ONE == CNT_MAX) begin
            accept     = 1'b1;
            cnt_next   = '0;
            state_next = RELEASE;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end else begin
          cnt_next   = '0;
          state_next = IDLE;
        end
      end
      RELEASE: begin
        if (data_valid) begin
          cnt_next = '0;
        end else if (cnt_reg + CNT_ONE == CNT_MAX) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  assign start_evt = start && !start_d_reg && !timer_busy;

  // Entry register. Priority clear > start > digit accept; a losing event
  // is dropped.
  always_comb begin
    entry_next      = entry_reg;
    count_next      = count_reg;
    load_value_next = load_value_reg;
    strobe_next     = 1'b0;
    load_next       = 1'b0;
    error_next      = 1'b0;
    if (clear) begin
      entry_next = '0;
      count_next = '0;
    end else if (start_evt) begin
      if (entry_valid(entry_reg)) begin
        load_value_next = entry_reg;
        load_next       = 1'b1;
        entry_next      = '0;
        count_next      = '0;
      end else begin
        error_next = 1'b1;
      end
    end else if (accept && (count_reg < 3'(MAX_DIGITS))) begin
      entry_next  = {entry_reg[ENTRY_W-BCD_W-1:0], accept_digit};
      count_next  = count_reg + 3'd1;
      strobe_next = 1'b1;
    end
  end

  assign entry       = entry_reg;
  assign digit_count = count_reg;
  assign key_strobe  = strobe_reg;
  assign load        = load_reg;
  assign load_value  = load_value_reg;
  assign entry_error = error_reg;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
module tb_keypad_entry_ctrl;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  keypad = '0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        timer_busy = 1'b0;
  logic [15:0] entry;
  logic [2:0]  digit_count;
  logic        key_strobe;
  logic        load;
  logic [15:0] load_value;
  logic        entry_error;

  keypad_entry_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .keypad      (keypad),
    .start       (start),
    .clear       (clear),
    .timer_busy  (timer_busy),
    .entry       (entry),
    .digit_count (digit_count),
    .key_strobe  (key_strobe),
    .load        (load),
    .load_value  (load_value),
    .entry_error (entry_error)
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Scoreboards: expected {entry, digit_count} per strobe, expected
  // load_value per load, one token per entry_error.
  logic [18:0] sb_q[$];
  logic [15:0] load_q[$];
  bit          err_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic        clr;
    int          digit;
    int          cycles;
    logic        exp_strobe;
    logic [15:0] exp_entry;
    logic [2:0]  exp_count;
  } row_t;

  row_t rows[13];

  // Output monitor, sampled on the falling edge.
  logic load_prev = 1'b0, err_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (key_strobe) begin
        check("strobe_expected", {31'd0, sb_q.size() != 0}, 32'd1);
        if (sb_q.size() != 0) begin
          logic [18:0] e;
          e = sb_q.pop_front();
          check("strobe_entry", {13'd0, entry, digit_count}, {13'd0, e});
        end
      end
      if (load) begin
        check("load_expected", {31'd0, load_q.size() != 0}, 32'd1);
        check("load_one_cycle", {31'd0, load_prev}, 32'd0);
        if (load_q.size() != 0) check("load_value", {16'd0, load_value}, {16'd0, load_q.pop_front()});
      end
      if (entry_error) begin
        check("error_expected", {31'd0, err_q.size() != 0}, 32'd1);
        check("error_one_cycle", {31'd0, err_prev}, 32'd0);
        if (err_q.size() != 0) void'(err_q.pop_front());
      end
      load_prev <= load;
      err_prev  <= entry_error;
    end else begin
      load_prev <= 1'b0;
      err_prev  <= 1'b0;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_row(input int i);
    if (rows[i].clr) begin
      clear = 1'b1;
      cycles(1);
      clear = 1'b0;
    end
    if (rows[i].exp_strobe) sb_q.push_back({rows[i].exp_entry, rows[i].exp_count});
    keypad = 10'(1 << rows[i].digit);
    cycles(rows[i].cycles);
    keypad = '0;
    cycles(2 * D + 4);
    $display("press key %0d for %0d cycles: entry=%04h count=%0d", rows[i].digit,
             rows[i].cycles, entry, digit_count);
    check($sformatf("row%0d_entry", i), {13'd0, entry, digit_count},
          {13'd0, rows[i].exp_entry, rows[i].exp_count});
  endtask

  task automatic do_start();
    start = 1'b1;
    cycles(3);
    start = 1'b0;
    cycles(3);
    $display("start: entry=%04h count=%0d load_value=%04h", entry, digit_count, load_value);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_strobe_q"}, sb_q.size(), 0);
    check({tag, "_load_q"}, load_q.size(), 0);
    check({tag, "_err_q"}, err_q.size(), 0);
  endtask

  initial begin
    rows[0]  = '{1'b0, 5, 10, 1'b1, 16'h0005, 3'd1};
    rows[1]  = '{1'b0, 7,  2, 1'b0, 16'h0005, 3'd1};
    rows[2]  = '{1'b1, 1,  8, 1'b1, 16'h0001, 3'd1};
    rows[3]  = '{1'b0, 2,  8, 1'b1, 16'h0012, 3'd2};
    rows[4]  = '{1'b0, 3,  8, 1'b1, 16'h0123, 3'd3};
    rows[5]  = '{1'b0, 0,  8, 1'b1, 16'h1230, 3'd4};
    rows[6]  = '{1'b0, 9,  8, 1'b0, 16'h1230, 3'd4};
    rows[7]  = '{1'b0, 1,  8, 1'b1, 16'h0001, 3'd1};
    rows[8]  = '{1'b0, 7,  8, 1'b1, 16'h0017, 3'd2};
    rows[9]  = '{1'b0, 0,  8, 1'b1, 16'h0170, 3'd3};
    rows[10] = '{1'b0, 4,  8, 1'b1, 16'h0004, 3'd1};
    rows[11] = '{1'b0, 5,  8, 1'b1, 16'h0045, 3'd2};
    rows[12] = '{1'b0, 8,  8, 1'b1, 16'h0008, 3'd1};

    cycles(3);
    check("reset_state", {entry, digit_count, key_strobe, load, load_value, entry_error},
          36'd0);
    rst_n = 1'b1;
    cycles(2);

    // Single key, short press, five-digit overflow.
    for (int i = 0; i <= 6; i++) apply_row(i);

    // Valid start.
    load_q.push_back(16'h1230);
    do_start();
    check("load_clears_entry", {13'd0, entry, digit_count}, 32'd0);
    check_drained("load");

    // sec_tens = 7 -> rejected.
    for (int i = 7; i <= 9; i++) apply_row(i);
    err_q.push_back(1'b1);
    do_start();
    check("error_keeps_entry", {16'd0, entry}, 32'h0170);
    check("load_value_holds", {16'd0, load_value}, 32'h1230);

    // Zero entry -> rejected.
    clear = 1'b1;
    cycles(1);
    clear = 1'b0;
    err_q.push_back(1'b1);
    do_start();
    check("zero_entry", {13'd0, entry, digit_count}, 32'd0);
    check_drained("error");

    // Timer busy: key and start ignored.
    timer_busy = 1'b1;
    keypad = 10'h008;
    cycles(10);
    start = 1'b1;
    cycles(3);
    start = 1'b0;
    keypad = '0;
    cycles(12);
    timer_busy = 1'b0;
    cycles(4);
    $display("busy press/start: entry=%04h count=%0d", entry, digit_count);
    check("busy_ignored", {13'd0, entry, digit_count}, 32'd0);
    check_drained("busy");

    // clear and start on the same edge.
    for (int i = 10; i <= 11; i++) apply_row(i);
    clear = 1'b1;
    start = 1'b1;
    cycles(1);
    clear = 1'b0;
    start = 1'b0;
    cycles(4);
    $display("clear+start: entry=%04h count=%0d", entry, digit_count);
    check("clear_beats_start", {13'd0, entry, digit_count}, 32'd0);
    check_drained("clear_start");

    // Asynchronous reset mid-debounce.
    apply_row(12);
    keypad = 10'h040;
    cycles(3);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset mid-debounce: entry=%04h load_value=%04h", entry, load_value);
    check("async_reset", {entry, digit_count, key_strobe, load, load_value, entry_error},
          36'd0);
    keypad = '0;
    cycles(2);
    rst_n = 1'b1;
    cycles(3 * D + 6);
    check("no_digit_after_reset", {13'd0, entry, digit_count}, 32'd0);
    check_drained("final");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
